// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vending_pkg
// Description : Shared states, constants and price helpers for the vending
//               machine, its buyer and their benches.
// Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    localparam int         PRODUCTNUM = 3;
    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] PO_NONE    = 2'd0;

    typedef enum logic [2:0] {
        LOAD0  = 3'd0,
        LOAD1  = 3'd1,
        LOAD2  = 3'd2,
        IDLE   = 3'd3,
        INSERT = 3'd4,
        SELECT = 3'd5,
        WAIT   = 3'd6,
        FINISH = 3'd7
    } state_t;

    // Entry 0 holds the price of product 1.
    typedef logic [PRODUCTNUM-1:0][7:0] price_arr_t;

    function automatic logic [7:0] price_of(input price_arr_t prices,
                                            input logic [1:0]  product);
        logic [7:0] v;
        v = 8'd0;
        case (product)
            2'd1:    v = prices[0];
            2'd2:    v = prices[1];
            2'd3:    v = prices[2];
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vending_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : vending_wait_timer
// Description : Down-counter loaded on selection; flags the last allowed
//               cycle of waiting for the product.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_CNT_W'(TIMEOUT);
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    // A count of one means this is the TIMEOUT-th waiting cycle.
    assign o_expired = i_run && (r_count <= c_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/vending_buyer.sv
`default_nettype none
// ============================================================================
// Module      : vending_buyer
// Description : Customer-side driver: loads prices, buys one product per
//               start and checks the product and change returned.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_buyer
    import vending_pkg::*;
#(
    parameter logic [7:0] PRICE0  = 8'd10,
    parameter logic [7:0] PRICE1  = 8'd20,
    parameter logic [7:0] PRICE2  = 8'd30,
    parameter int         TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] target,
    input  logic [7:0] coin,
    output logic       ready,
    output logic       done,
    output logic       ok,
    output logic [7:0] change,
    output logic [7:0] DI,
    output logic [7:0] MI,
    output logic [1:0] sel,
    input  logic [7:0] MO,
    input  logic [1:0] PO
);

    localparam price_arr_t c_PRICES = {PRICE2, PRICE1, PRICE0};

    state_t     r_state;
    logic [1:0] r_target;
    logic [7:0] r_coin;
    logic [7:0] r_price;
    logic [8:0] r_paid;
    logic       r_ready;
    logic       r_done;
    logic       r_ok;
    logic [7:0] r_change;
    logic [7:0] r_di;
    logic [7:0] r_mi;
    logic [1:0] r_sel;

    logic [7:0] w_price;
    logic [8:0] w_sum;
    logic [7:0] w_exp_change;
    logic       w_expired;

    assign w_price      = price_of(c_PRICES, target);
    assign w_sum        = r_paid + {1'b0, r_coin};
    // paid >= price whenever this is consulted, so the difference cannot wrap.
    assign w_exp_change = r_paid[7:0] - r_price;

    vending_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == SELECT),
        .i_run     (r_state == WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD0;
            r_target <= 2'd0;
            r_coin   <= 8'd0;
            r_price  <= 8'd0;
            r_paid   <= 9'd0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_ok     <= 1'b0;
            r_change <= 8'd0;
            r_di     <= 8'd0;
            r_mi     <= 8'd0;
            r_sel    <= SEL_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD0: begin
                    r_di    <= PRICE0;
                    r_state <= LOAD1;
                end
                LOAD1: begin
                    r_di    <= PRICE1;
                    r_state <= LOAD2;
                end
                LOAD2: begin
                    r_di    <= PRICE2;
                    r_state <= IDLE;
                end
                IDLE: begin
                    r_di  <= 8'd0;
                    r_mi  <= 8'd0;
                    r_sel <= SEL_NONE;
                    if (r_ready && start) begin
                        r_ready  <= 1'b0;
                        r_target <= target;
                        r_coin   <= coin;
                        r_price  <= w_price;
                        r_paid   <= 9'd0;
                        r_ok     <= 1'b0;
                        if (target == 2'd0) begin
                            r_change <= 8'd0;
                            r_state  <= FINISH;
                        end else if (w_price == 8'd0) begin
                            r_state <= SELECT;
                        end else if (coin == 8'd0) begin
                            r_change <= 8'd0;
                            r_state  <= FINISH;
                        end else begin
                            r_state <= INSERT;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                INSERT: begin
                    if (w_sum > 9'd255) begin
                        r_mi     <= 8'd0;
                        r_ok     <= 1'b0;
                        r_change <= 8'd0;
                        r_state  <= FINISH;
                    end else begin
                        r_mi   <= r_coin;
                        r_paid <= w_sum;
                        if (w_sum >= {1'b0, r_price}) begin
                            r_state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    r_mi    <= 8'd0;
                    r_sel   <= r_target;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_mi  <= 8'd0;
                    r_sel <= SEL_NONE;
                    if (PO != PO_NONE) begin
                        r_change <= MO;
                        r_ok     <= (PO == r_target) && (MO == w_exp_change);
                        r_state  <= FINISH;
                    end else if (w_expired) begin
                        r_change <= 8'd0;
                        r_ok     <= 1'b0;
                        r_state  <= FINISH;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= LOAD0;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign ok     = r_ok;
    assign change = r_change;
    assign DI     = r_di;
    assign MI     = r_mi;
    assign sel    = r_sel;

endmodule
`default_nettype wire

// File: doc/vending_buyer.md
# vending_buyer

Customer-side driver for the vending machine block: it owns the DI/MI/sel inputs of the machine and consumes its MO/PO outputs. After reset it loads the three product prices into the machine. On each `start` it then inserts coins until the chosen product is paid for, presses the selection, and waits for the product and change. It checks the returned change and product, then reports pass/fail and the change received. It sits between a test or controller layer and the vending machine, and also serves as a synthesizable self-checking stimulus source.

## Interface
- PRICE0, 8'd10, price loaded for product 1
- PRICE1, 8'd20, price loaded for product 2
- PRICE2, 8'd30, price loaded for product 3
- TIMEOUT, 16, max cycles waited for PO after selection
- clk  in  1  system clock; one clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request pulse; ignored unless `ready`=1
- target  in  2  product to buy (1..3); 0 = invalid
- coin  in  8  coin value inserted per insert cycle; sampled with `start`
- ready  out  1  idle and accepting `start`
- done  out  1  one-cycle pulse when a purchase attempt ends
- ok  out  1  valid with `done`: product and change both correct
- change  out  8  MO captured at delivery; held until next `done`
- DI  out  8  price byte to machine
- MI  out  8  money in to machine
- sel  out  2  selection to machine; 0 = none
- MO  in  8  change from machine
- PO  in  2  product from machine; 0 = none

## Operation
- Machine protocol:
  - The first 3 post-reset cycles carry PRICE0, PRICE1, PRICE2 on DI, in that order.
  - Afterwards, each cycle presents MI (coin value, 0 = none) and sel.
  - The machine answers with PO != 0 plus MO when a product is vended.
- States:
  - LOAD0/1/2: one cycle each; drive DI = PRICEn, MI = 0, sel = 0. LOAD2 -> IDLE.
  - IDLE: `ready`=1. On `start`, latch target, coin and price[target]; clear `paid`.
    - target 0 -> FINISH with ok = 0.
    - latched price 0 -> SELECT.
    - coin 0 with price > 0 -> FINISH with ok = 0.
    - Otherwise -> INSERT.
  - INSERT: drive MI = coin and `paid` += coin each cycle. When the new paid >= price -> SELECT.
    - `paid` is 9 bits. A sum > 255 ends in FINISH with ok = 0, MI = 0 from the next cycle.
  - SELECT: one cycle; drive sel = target, MI = 0 -> WAIT.
  - WAIT: sel = 0, MI = 0; count cycles.
    - PO != 0: capture MO into `change`. ok = (PO == target) && (MO == paid - price). -> FINISH.
    - TIMEOUT cycles with PO = 0: ok = 0, change = 0 -> FINISH.
  - FINISH: `done`=1 for one cycle -> IDLE.
- Arithmetic: expected change = paid[7:0] - price, computed 8-bit with no wrap because paid >= price. Comparison is exact.
- `start` outside IDLE is dropped, not queued.
- PO != 0 outside WAIT is ignored.

## Timing
- Reset values: DI = 0, MI = 0, sel = 0, ready = 0, done = 0, ok = 0, change = 0. State is LOAD0.
- `rst` in any state, mid-purchase included, returns to LOAD0 on the next edge. Prices are reloaded.
- All outputs are registered and change only on posedge clk.
- `ready` is first high 3 cycles after rst deasserts.
- `start` is sampled at the IDLE edge. The first MI = coin appears in the next cycle.
- Total latency for n coins with the machine responding k cycles after SELECT: `done` comes n + 1 + k + 1 cycles after `start` (FINISH is the cycle after PO is seen).
- `ok` and `change` are valid in the `done` cycle. `change` holds afterwards; `ok` holds until the next `start`.

## Structure
- A shared package `vending_pkg` holds:
  - the state enum;
  - the SEL_NONE / PO_NONE = 2'd0 constants;
  - the PRODUCTNUM = 3 constant;
  - the price array type.
  The vending machine and its bench import the same package.
- One natural sub-module is `vending_wait_timer`: a down-counter loaded with TIMEOUT on SELECT that flags expiry in WAIT.
- The top holds the FSM, the `paid` accumulator and the checker.

## Test plan
- Reset release -> DI = 10, 20, 30 on three consecutive cycles; ready = 1 on the 4th cycle.
- target = 2, coin = 5, machine returns PO = 2, MO = 0 -> 4 MI = 5 cycles, sel = 2 one cycle, done with ok = 1, change = 0.
- target = 1, coin = 7, machine returns PO = 1, MO = 4 -> 2 coins, ok = 1, change = 4. Same scenario with MO = 3 -> ok = 0, change = 3.
- target = 3, machine never asserts PO -> done exactly TIMEOUT + 1 cycles after SELECT, ok = 0, change = 0.
- target = 0, and separately coin = 0 with price > 0 -> no MI or sel activity; done 1 cycle after start with ok = 0. A start held during INSERT has no effect.
- rst asserted during INSERT -> all outputs 0 next cycle, then LOAD0/1/2 replay the prices; a later purchase completes with ok = 1.
